// File: rtl/uart_dma_pkg.sv
// Shared types and constants for the UART DMA responder.
// Contents: FSM state enum, DMA direction encodings, full-word Wishbone select.
package uart_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACK    = 3'd1,
      ST_RD_BUS = 3'd2,
      ST_PUSH   = 3'd3,
      ST_PULL   = 3'd4,
      ST_WR_BUS = 3'd5,
      ST_DONE   = 3'd6
   } dma_state_e;

   localparam logic       DMA_DIR_TX  = 1'b0;
   localparam logic       DMA_DIR_RX  = 1'b1;
   localparam logic [3:0] WB_SEL_WORD = 4'hF;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 16;

endpackage

// File: rtl/uart_dma_engine.sv
// DMA responder for the UART request/ack DMA port. Accepts a transfer request
// (direction, start address, beat count) and moves 32-bit words between the
// UART and memory through a single-outstanding Wishbone master.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dma_req_i/ack_o/dir_i/addr_i/len_i   request handshake and descriptor
//   dma_valid_o/ready_i/rdata_o/wdata_i  per-word UART handshake
//   wbm_*                        Wishbone master request/response
//   busy_o, done_o, err_o, xfer_cnt_o    status
// Every output is a flop; output next-values are decoded from the next state.
module uart_dma_engine
   import uart_dma_pkg::*;
#(
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dma_req_i,
   output logic                dma_ack_o,
   input  logic                dma_dir_i,
   input  logic [ADDR_W-1:0]   dma_addr_i,
   input  logic [LEN_W-1:0]    dma_len_i,
   output logic                dma_valid_o,
   output logic [DATA_W-1:0]   dma_rdata_o,
   input  logic                dma_ready_i,
   input  logic [DATA_W-1:0]   dma_wdata_i,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   output logic [3:0]          wbm_sel_o,
   output logic                wbm_we_o,
   output logic                wbm_stb_o,
   output logic                wbm_cyc_o,
   input  logic [DATA_W-1:0]   wbm_dat_i,
   input  logic                wbm_ack_i,
   input  logic                wbm_err_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [LEN_W-1:0]    xfer_cnt_o
);

   dma_state_e         state_q, state_d;
   logic               dir_q, dir_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  buf_q, buf_d;
   logic               abort_q, abort_d;
   logic               beat;
   logic               bus_req_q, bus_req_d;
   logic               ack_d, valid_d, we_d, busy_d, done_d, err_d;
   logic [3:0]         sel_d;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      abort_d = abort_q;
      beat    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dma_req_i) begin
               dir_d   = dma_dir_i;
               addr_d  = dma_addr_i;
               rem_d   = dma_len_i;
               cnt_d   = '0;
               abort_d = 1'b0;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (rem_q == '0)              state_d = ST_DONE;
            else if (dir_q == DMA_DIR_RX) state_d = ST_PULL;
            else                          state_d = ST_RD_BUS;
         end
         ST_RD_BUS: begin
            // err wins over ack when both arrive together
            if (wbm_err_i) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (wbm_ack_i) begin
               buf_d   = wbm_dat_i;
               state_d = ST_PUSH;
            end
         end
         ST_PUSH: begin
            if (dma_ready_i) beat = 1'b1;
         end
         ST_PULL: begin
            if (dma_ready_i) begin
               buf_d   = dma_wdata_i;
               state_d = ST_WR_BUS;
            end
         end
         ST_WR_BUS: begin
            if (wbm_err_i) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (wbm_ack_i) begin
               beat = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Beat completion; the address wraps modulo 2^32 by design.
      if (beat) begin
         cnt_d  = cnt_q + LEN_W'(1);
         addr_d = addr_q + ADDR_W'(ADDR_STEP);
         rem_d  = rem_q - LEN_W'(1);
         if (rem_q == LEN_W'(1))       state_d = ST_DONE;
         else if (dir_q == DMA_DIR_RX) state_d = ST_PULL;
         else                          state_d = ST_RD_BUS;
      end

      ack_d     = (state_d == ST_ACK);
      valid_d   = (state_d == ST_PUSH) || (state_d == ST_PULL);
      bus_req_d = (state_d == ST_RD_BUS) || (state_d == ST_WR_BUS);
      we_d      = (state_d == ST_WR_BUS);
      sel_d     = bus_req_d ? WB_SEL_WORD : 4'h0;
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      err_d     = done_d && abort_d;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dir_q       <= 1'b0;
         addr_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         buf_q       <= '0;
         abort_q     <= 1'b0;
         bus_req_q   <= 1'b0;
         dma_ack_o   <= 1'b0;
         dma_valid_o <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= 4'h0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         abort_q     <= abort_d;
         bus_req_q   <= bus_req_d;
         dma_ack_o   <= ack_d;
         dma_valid_o <= valid_d;
         wbm_we_o    <= we_d;
         wbm_sel_o   <= sel_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
         err_o       <= err_d;
      end
   end

   assign wbm_stb_o   = bus_req_q;
   assign wbm_cyc_o   = bus_req_q;
   assign wbm_adr_o   = addr_q;
   assign wbm_dat_o   = buf_q;
   assign dma_rdata_o = buf_q;
   assign xfer_cnt_o  = cnt_q;

endmodule

// File: doc/uart_dma_engine.md
# uart_dma_engine

DMA responder for the UART peripheral's simple request/ack DMA port. Accepts a transfer request (direction, start address, beat count) from the UART, then moves 32-bit words between the UART and system memory through a single-outstanding Wishbone master. This block is the other end of the UART's DMA interface: UART DMA port on one side, system Wishbone bus on the other.

## Interface
- ADDR_STEP, 4, byte increment applied to the memory address after each beat
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dma_req_i  in  1  transfer request from UART, held until acked
- dma_ack_o  out  1  one-cycle request acceptance pulse
- dma_dir_i  in  1  0: memory→UART (TX), 1: UART→memory (RX); sampled with req
- dma_addr_i  in  32  start memory address; sampled with req
- dma_len_i  in  16  beat count; sampled with req
- dma_valid_o  out  1  TX: dma_rdata_o valid; RX: engine can take a word
- dma_rdata_o  out  32  word to UART (TX)
- dma_ready_i  in  1  TX: UART takes word; RX: dma_wdata_i valid
- dma_wdata_i  in  32  word from UART (RX)
- wbm_adr_o  out  32 / wbm_dat_o  out  32 / wbm_sel_o  out  4 / wbm_we_o  out  1 / wbm_stb_o  out  1 / wbm_cyc_o  out  1  Wishbone master request
- wbm_dat_i  in  32 / wbm_ack_i  in  1 / wbm_err_i  in  1  Wishbone master response
- busy_o  out  1  high from ACK through DONE
- done_o  out  1  one-cycle pulse at transfer end
- err_o  out  1  one-cycle pulse with done_o when aborted by wbm_err_i
- xfer_cnt_o  out  16  beats completed in current/last transfer

## Operation
- States: IDLE, ACK, RD_BUS, PUSH, PULL, WR_BUS, DONE.
- IDLE: on dma_req_i=1, latch dir/addr/len, clear xfer_cnt_o, → ACK. Requests are ignored in all other states.
- ACK: dma_ack_o=1 for exactly this cycle. len=0 → DONE; dir=0 → RD_BUS; dir=1 → PULL.
- RD_BUS (TX): cyc=stb=1, we=0, sel=4'hF, adr=cur_addr until wbm_ack_i; capture wbm_dat_i into the beat buffer, → PUSH.
- PUSH (TX): dma_valid_o=1, dma_rdata_o=buffer until dma_ready_i; the beat completes.
- PULL (RX): dma_valid_o=1 until dma_ready_i; capture dma_wdata_i, → WR_BUS.
- WR_BUS (RX): cyc=stb=we=1, sel=4'hF, dat_o=buffer until wbm_ack_i; the beat completes.
- Beat completion: xfer_cnt_o+1, cur_addr+=ADDR_STEP (mod 2^32, wraps silently), remaining-1. remaining=0 → DONE, else RD_BUS/PULL.
- wbm_err_i while stb high: abort, no count increment, → DONE with err flag set.
- DONE: done_o=1 (err_o=1 if aborted) for one cycle, → IDLE.
- Beat transfer on UART side is valid&&ready in both directions; on bus side stb&&(ack||err). ack and err together count as err.

## Timing
- All outputs registered. Reset value of every output is 0; state → IDLE, counters cleared. Reset mid-transfer drops the in-flight beat with no done_o.
- Request sampled at edge n → dma_ack_o high in cycle n+1 only. The UART drops req after seeing ack. The engine cannot re-accept before DONE→IDLE, so a held req is never double-acked.
- stb/cyc deassert in the cycle after the ack/err is sampled. There are no back-to-back strobes, so a slave that gates on its own ack is never double-hit.
- With a registered-ack slave and ready held high: 3 cycles per beat (bus request, ack, UART handshake). 1+3·len+1 cycles from ack to done_o.
- len=0: ACK→DONE with zero bus cycles; done_o 2 cycles after req sampled.
- dma_valid_o and wbm_stb_o are never high in the same cycle.
- len=65535 is supported; the 16-bit counter never overflows.

## Structure
- Shared package uart_dma_pkg: state enum, DMA_DIR_TX=1'b0 / DMA_DIR_RX=1'b1 constants, WB_SEL_WORD=4'hF.
- Flat single FSM with one 32-bit beat buffer. No sub-module is needed.

## Test plan
- Reset during RD_BUS of a TX transfer: all outputs 0 next cycle, busy_o=0, no done_o.
- TX, addr=0x1000_0000, len=3, slave ack one cycle after stb, ready always high: reads at 0x1000_0000/04/08, words delivered in order, done_o after 11 cycles from ack, xfer_cnt_o=3.
- RX, addr=0x2000_0010, len=2, UART ready stalls 5 cycles per word: writes of the exact wdata words at 0x2000_0010/14, we=1, sel=4'hF, done_o once.
- len=0: single ack pulse, no stb, done_o 2 cycles after req; req held 1 extra cycle is not re-acked.
- RX len=4 with wbm_err_i on 2nd write: done_o and err_o pulse together, xfer_cnt_o=1, no further bus or UART activity.
- addr=0xFFFF_FFFC, len=2, TX: second read at 0x0000_0000.
